// File: rtl/cfg_shift_loader_pkg.sv
// Shared constants and state encoding for the configuration shift loader.
// Field offsets describe where each cipher config field sits inside the 66-bit frame.
package cfg_shift_loader_pkg;

  localparam int M          = 32;
  localparam int CFG_W      = 2 * M + 2;
  localparam int NBYTES     = (CFG_W + 7) / 8;
  localparam int LAST_BYTE  = NBYTES - 1;
  localparam int LAST_BIT   = CFG_W - 1;
  localparam int TAIL_BITS  = CFG_W - 8 * LAST_BYTE;
  localparam int BYTE_CNT_W = 4;
  localparam int BIT_CNT_W  = 7;

  localparam int A_MUX_BIT  = 65;
  localparam int D_EN_BIT   = 64;
  localparam int TAPS_LSB   = 32;
  localparam int STATE_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/cfg_shift_loader.sv
// Collects a 9-byte config frame, shifts it LSB-first into the cipher cfg chain,
// and captures the displaced chain contents as a readback word.
module cfg_shift_loader
  import cfg_shift_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CFG_W-1:0] rb_data,
  output logic             cfg_en,
  output logic             cfg_i,
  input  logic             cfg_o
);

  state_t                 state;
  state_t                 next_state;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [CFG_W-1:0]       shreg;
  logic [CFG_W-1:0]       rb_shift;
  logic                   hs;
  logic                   last_byte;
  logic                   last_bit;

  assign hs        = wr_valid & wr_ready;
  assign last_byte = (byte_cnt == BYTE_CNT_W'(LAST_BYTE));
  assign last_bit  = (bit_cnt == BIT_CNT_W'(LAST_BIT));

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (!abort && hs && last_byte) next_state = ST_SHIFT;
      ST_SHIFT: begin
        if (abort)         next_state = ST_IDLE;
        else if (last_bit) next_state = ST_DONE;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // NOTE: the wide shift/readback registers are reset too, so readback after reset is a defined zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      rb_shift <= '0;
      rb_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Abort outranks a same-cycle handshake: the byte is dropped with the partial frame.
          if (abort) begin
            byte_cnt <= '0;
          end else if (hs) begin
            if (last_byte) begin
              shreg[CFG_W-1:8*LAST_BYTE] <= wr_data[TAIL_BITS-1:0];
              byte_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              shreg[{byte_cnt[2:0], 3'b000} +: 8] <= wr_data;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          shreg    <= shreg >> 1;
          rb_shift <= {cfg_o, rb_shift[CFG_W-1:1]};
          if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
        end
        ST_DONE:  rb_data <= rb_shift;
        default:  ;
      endcase
    end
  end

  // Handshake and chain controls are flops decoded from next_state, so no input reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      cfg_en   <= 1'b0;
      cfg_i    <= 1'b0;
    end else begin
      wr_ready <= (next_state == ST_IDLE);
      busy     <= (next_state != ST_IDLE);
      done     <= (next_state == ST_DONE);
      aborted  <= (state == ST_SHIFT) && abort;
      cfg_en   <= (next_state == ST_SHIFT);
      // While shifting, shreg[1] is the bit that becomes shreg[0] after this edge.
      cfg_i    <= (next_state == ST_SHIFT) && ((state == ST_SHIFT) ? shreg[1] : shreg[0]);
    end
  end

endmodule

// File: tb/tb_cfg_shift_loader.sv
// Bench for cfg_shift_loader with a behavioural 66-bit cipher cfg chain.
// Stimulus pushes expected load/abort events; a monitor pops and compares on done/aborted.
module tb_cfg_shift_loader;
  import cfg_shift_loader_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       wr_data = 8'h00;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CFG_W-1:0] rb_data;
  logic             cfg_en;
  logic             cfg_i;
  logic             cfg_o;
  logic [CFG_W-1:0] chain;

  cfg_shift_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .rb_data  (rb_data),
    .cfg_en   (cfg_en),
    .cfg_i    (cfg_i),
    .cfg_o    (cfg_o)
  );

  always #5 clk = ~clk;

  // Cipher cfg chain: shifts right, cfg_i enters the MSB, cfg_o is the LSB.
  assign cfg_o = chain[0];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      chain <= '0;
    else if (cfg_en) chain <= {cfg_i, chain[CFG_W-1:1]};
  end

  // Byte vectors {byte8, ..., byte0} and the hand-packed 66-bit frames they produce.
  localparam logic [71:0] B1 = 72'h00_48000000_00000055;
  localparam logic [65:0] F1 = 66'h0_48000000_00000055;
  localparam logic [71:0] BA = 72'h03_88776655_44332211;
  localparam logic [65:0] FA = 66'h3_88776655_44332211;
  localparam logic [71:0] BB = 72'hFE_78695A4B_3C2D1E0F;
  localparam logic [65:0] FB = 66'h2_78695A4B_3C2D1E0F;
  localparam logic [71:0] BC = 72'h01_08070605_04030201;
  localparam logic [65:0] FC = 66'h1_08070605_04030201;
  localparam logic [71:0] BD = 72'h02_1706F5E4_D3C2B1A0;

  typedef struct {
    bit          is_abort;
    logic [65:0] frame;
    logic [65:0] rb;
    int          en_cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_run = 0;
  int   rdy_low = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold);
    int guard;
    guard = 0;
    wr_data  = b;
    wr_valid = 1'b1;
    while (!wr_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!wr_ready) begin
      checks++;
      errors++;
      $display("FAIL wr_ready_timeout: wr_ready stayed %b, required 1", wr_ready);
    end
    @(posedge clk); #1;
    if (!hold) wr_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] bytes, input bit hold);
    for (int k = 0; k < NBYTES; k++) send_byte(bytes[8*k +: 8], hold);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 400) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending=%0d busy=%b, required 0 and 0", sb.size(), busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: tracks run lengths and checks each done/aborted event against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_run  = 0;
        rdy_low = 0;
        continue;
      end
      rdy_low = wr_ready ? 0 : rdy_low + 1;
      if (done || aborted) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: done=%b aborted=%b with nothing expected", done, aborted);
        end else begin
          e = sb.pop_front();
          check_int("aborted_pulse", int'(aborted), int'(e.is_abort));
          check_int("done_pulse", int'(done), int'(!e.is_abort));
          check_int("cfg_en_run", en_run, e.en_cycles);
          check_int("cfg_en_dropped", int'(cfg_en), 0);
          if (!e.is_abort) begin
            check("chain_loaded", chain, e.frame);
            check_int("busy_in_done", int'(busy), 1);
            check_int("wr_ready_low_run", rdy_low, 67);
            @(negedge clk);
            check("rb_data", rb_data, e.rb);
            check_int("wr_ready_after_done", int'(wr_ready), 1);
            rdy_low = 0;
          end else begin
            check_int("wr_ready_after_abort", int'(wr_ready), 1);
            check_int("busy_after_abort", int'(busy), 0);
            check("rb_data_unchanged", rb_data, e.rb);
          end
        end
      end
      en_run = cfg_en ? en_run + 1 : 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1;
    check_int("rst_cfg_en", int'(cfg_en), 0);
    check_int("rst_cfg_i", int'(cfg_i), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_aborted", int'(aborted), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_int("wr_ready_after_reset", int'(wr_ready), 1);
    check("rb_data_after_reset", rb_data, '0);

    // Single load
    sb.push_back('{1'b0, F1, 66'd0, 66});
    send_frame(B1, 1'b0);
    wait_idle();

    // Back-to-back loads: readback of B is frame A
    sb.push_back('{1'b0, FA, F1, 66});
    send_frame(BA, 1'b0);
    wait_idle();
    check_int("a_mux_in_chain", int'(chain[A_MUX_BIT]), 1);
    check_int("d_en_in_chain", int'(chain[D_EN_BIT]), 1);
    sb.push_back('{1'b0, FB, FA, 66});
    send_frame(BB, 1'b0);
    wait_idle();

    // Partial frame then abort (with a colliding byte that must be dropped)
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    wr_data  = 8'hEE;
    wr_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_int("idle_abort_no_shift", int'(cfg_en), 0);
    check_int("idle_abort_not_busy", int'(busy), 0);
    sb.push_back('{1'b0, FC, FB, 66});
    send_frame(BC, 1'b0);
    wait_idle();

    // Abort during shift cycle 20
    sb.push_back('{1'b1, 66'd0, FB, 20});
    send_frame(BD, 1'b0);
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle();

    // Async reset in the middle of a shift
    send_frame(BA, 1'b0);
    repeat (29) @(posedge clk);
    #2;
    check_int("shift_active_before_reset", int'(cfg_en), 1);
    rst_n = 1'b0;
    #1;
    check_int("async_rst_cfg_en", int'(cfg_en), 0);
    check_int("async_rst_cfg_i", int'(cfg_i), 0);
    check_int("async_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_int("wr_ready_after_mid_reset", int'(wr_ready), 1);
    check("rb_data_after_mid_reset", rb_data, '0);

    // 18 bytes with wr_valid held high throughout
    sb.push_back('{1'b0, FA, 66'd0, 66});
    sb.push_back('{1'b0, F1, FA, 66});
    send_frame(BA, 1'b1);
    send_frame(B1, 1'b1);
    wr_valid = 1'b0;
    wait_idle();

    check_int("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
